// File: rtl/vga_layer_pkg.sv
// Shared types and constants for the VGA layer arbiter.
//   ADDR_W / RGB_W : pixel address width and RGB565 pixel width
//   H_ACT / V_ACT  : active area size (addresses are 1-based, 0 = blanking)
//   win_t          : one layer window (enable + inclusive bounds)
//   cfg_state_e    : configuration commit FSM states
package vga_layer_pkg;

   localparam int ADDR_W = 12;
   localparam int RGB_W  = 16;
   localparam int H_ACT  = 640;
   localparam int V_ACT  = 480;

   typedef struct packed {
      logic              en;
      logic [ADDR_W-1:0] x0;
      logic [ADDR_W-1:0] x1;
      logic [ADDR_W-1:0] y0;
      logic [ADDR_W-1:0] y1;
   } win_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_COMMIT  = 2'd2
   } cfg_state_e;

endpackage

// File: rtl/vga_layer_window.sv
// Stage-1 window compare for one layer.
//   clk, rst_n         : clock, async active-low reset
//   win_i              : active window of this layer
//   addr_h_i, addr_v_i : 1-based pixel address (0 = blanking)
//   hit_o              : registered window hit
//   rel_h_o, rel_v_o   : registered window-relative coordinates, 0 when not hit
module vga_layer_window
   import vga_layer_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  win_t              win_i,
   input  logic [ADDR_W-1:0] addr_h_i,
   input  logic [ADDR_W-1:0] addr_v_i,
   output logic              hit_o,
   output logic [ADDR_W-1:0] rel_h_o,
   output logic [ADDR_W-1:0] rel_v_o
);

   logic              hit_d, hit_q;
   logic [ADDR_W-1:0] rel_h_d, rel_h_q;
   logic [ADDR_W-1:0] rel_v_d, rel_v_q;

   // An inverted window (x0 > x1 or y0 > y1) fails the range test naturally.
   always_comb begin
      hit_d   = win_i.en
              && (addr_h_i != '0) && (addr_v_i != '0)
              && (addr_h_i >= win_i.x0) && (addr_h_i <= win_i.x1)
              && (addr_v_i >= win_i.y0) && (addr_v_i <= win_i.y1);
      rel_h_d = '0;
      rel_v_d = '0;
      if (hit_d) begin
         rel_h_d = addr_h_i - win_i.x0;
         rel_v_d = addr_v_i - win_i.y0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_q   <= 1'b0;
         rel_h_q <= '0;
         rel_v_q <= '0;
      end else begin
         hit_q   <= hit_d;
         rel_h_q <= rel_h_d;
         rel_v_q <= rel_v_d;
      end
   end

   assign hit_o   = hit_q;
   assign rel_h_o = rel_h_q;
   assign rel_v_o = rel_v_q;

endmodule

// File: rtl/vga_layer_arbiter.sv
// Pixel scheduler between the VGA timing driver and N_LAYER content layers.
// Window config is written into a shadow bank and copied to the active bank
// on the first v_sync falling edge after a write. Pixel path: addr -> layer
// hit/rel (1 cycle) -> rgb_data (2 cycles).
// Optional build macro LAYER_COLORKEY_EN: layer pixels equal to KEY_COLOR are
// treated as transparent and selection falls through to lower layers.
//
// state   | meaning
// IDLE    | no uncommitted shadow writes, cfg_ready = 1
// PENDING | shadow differs from active, waiting for v_sync falling edge
// COMMIT  | one cycle: active <= shadow, frame_commit = 1, cfg_ready = 0
//
// Ports: clk, rst_n; addr_h/addr_v/v_sync from driver; cfg_* valid/ready
// write port and sticky cfg_err; layer_hit/layer_rel_h/layer_rel_v to layers;
// layer_rgb from layers; rgb_data to driver; frame_commit pulse.
module vga_layer_arbiter
   import vga_layer_pkg::*;
#(
   parameter int               N_LAYER   = 4,
   parameter logic [RGB_W-1:0] BG_COLOR  = 16'h0000,
   parameter logic [RGB_W-1:0] KEY_COLOR = 16'hF81F
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [ADDR_W-1:0]         addr_h,
   input  logic [ADDR_W-1:0]         addr_v,
   input  logic                      v_sync,
   input  logic                      cfg_valid,
   output logic                      cfg_ready,
   input  logic [2:0]                cfg_layer,
   input  logic                      cfg_en,
   input  logic [ADDR_W-1:0]         cfg_x0,
   input  logic [ADDR_W-1:0]         cfg_x1,
   input  logic [ADDR_W-1:0]         cfg_y0,
   input  logic [ADDR_W-1:0]         cfg_y1,
   output logic                      cfg_err,
   output logic [N_LAYER-1:0]        layer_hit,
   output logic [N_LAYER*ADDR_W-1:0] layer_rel_h,
   output logic [N_LAYER*ADDR_W-1:0] layer_rel_v,
   input  logic [N_LAYER*RGB_W-1:0]  layer_rgb,
   output logic [RGB_W-1:0]          rgb_data,
   output logic                      frame_commit
);

`ifdef LAYER_COLORKEY_EN
   localparam logic KEY_EN = 1'b1;
`else
   localparam logic KEY_EN = 1'b0;
`endif

   cfg_state_e       state_q, state_d;
   win_t             shadow_q [N_LAYER];
   win_t             active_q [N_LAYER];
   win_t             cfg_win;
   logic             vs_q;
   logic             vs_fall;
   logic             cfg_xfer;
   logic             cfg_good;
   logic             err_q;
   logic [N_LAYER-1:0] key_match;
   logic [N_LAYER-1:0] eff_hit;
   logic [RGB_W-1:0] rgb_d, rgb_q;

   assign cfg_win  = '{en: cfg_en, x0: cfg_x0, x1: cfg_x1, y0: cfg_y0, y1: cfg_y1};
   assign cfg_xfer = cfg_valid && cfg_ready;
   assign cfg_good = (int'(cfg_layer) < N_LAYER);
   assign vs_fall  = vs_q && !v_sync;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next state; an out-of-range write never moves the FSM
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (cfg_xfer && cfg_good) state_d = ST_PENDING;
         ST_PENDING: if (vs_fall)              state_d = ST_COMMIT;
         ST_COMMIT:                            state_d = ST_IDLE;
         default:                              state_d = ST_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      cfg_ready    = 1'b1;
      frame_commit = 1'b0;
      if (state_q == ST_COMMIT) begin
         cfg_ready    = 1'b0;
         frame_commit = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_q  <= 1'b1;
         err_q <= 1'b0;
         for (int i = 0; i < N_LAYER; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
      end else begin
         vs_q <= v_sync;
         if (cfg_xfer && !cfg_good) err_q <= 1'b1;
         for (int i = 0; i < N_LAYER; i++) begin
            if (cfg_xfer && cfg_good && (cfg_layer == 3'(i))) shadow_q[i] <= cfg_win;
         end
         // A write in the edge cycle already landed in shadow_q, so it is copied here.
         if (state_q == ST_COMMIT) active_q <= shadow_q;
      end
   end

   assign cfg_err = err_q;

   for (genvar g = 0; g < N_LAYER; g++) begin : g_win
      vga_layer_window u_win (
         .clk      (clk),
         .rst_n    (rst_n),
         .win_i    (active_q[g]),
         .addr_h_i (addr_h),
         .addr_v_i (addr_v),
         .hit_o    (layer_hit[g]),
         .rel_h_o  (layer_rel_h[g*ADDR_W +: ADDR_W]),
         .rel_v_o  (layer_rel_v[g*ADDR_W +: ADDR_W])
      );
      assign key_match[g] = (layer_rgb[g*RGB_W +: RGB_W] == KEY_COLOR);
   end

   assign eff_hit = layer_hit & ~(key_match & {N_LAYER{KEY_EN}});

   // Highest index wins because later iterations overwrite earlier ones.
   always_comb begin
      rgb_d = BG_COLOR;
      for (int i = 0; i < N_LAYER; i++) begin
         if (eff_hit[i]) rgb_d = layer_rgb[i*RGB_W +: RGB_W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rgb_q <= '0;
      else        rgb_q <= rgb_d;
   end

   assign rgb_data = rgb_q;

endmodule

// File: tb/tb_vga_layer_arbiter.sv
module tb_vga_layer_arbiter;

   localparam int N   = 4;
   localparam int AW  = 12;
   localparam int RW  = 16;
   localparam logic [RW-1:0] BG  = 16'h0000;
   localparam logic [RW-1:0] KEY = 16'hF81F;
`ifdef LAYER_COLORKEY_EN
   localparam bit KEYEN = 1'b1;
`else
   localparam bit KEYEN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_n;
   logic [AW-1:0]   addr_h, addr_v;
   logic            v_sync;
   logic            cfg_valid, cfg_ready;
   logic [2:0]      cfg_layer;
   logic            cfg_en;
   logic [AW-1:0]   cfg_x0, cfg_x1, cfg_y0, cfg_y1;
   logic            cfg_err;
   logic [N-1:0]    layer_hit;
   logic [N*AW-1:0] layer_rel_h, layer_rel_v;
   logic [N*RW-1:0] layer_rgb;
   logic [RW-1:0]   rgb_data;
   logic            frame_commit;

   int checks = 0;
   int errors = 0;

   // Reference model: active and shadow window banks, pending flag, sticky error.
   int en_a[N], x0_a[N], x1_a[N], y0_a[N], y1_a[N];
   int en_s[N], x0_s[N], x1_s[N], y0_s[N], y1_s[N];
   bit pend_m;
   bit err_m;

   vga_layer_arbiter #(.N_LAYER(N), .BG_COLOR(BG), .KEY_COLOR(KEY)) dut (
      .clk(clk), .rst_n(rst_n), .addr_h(addr_h), .addr_v(addr_v), .v_sync(v_sync),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_layer(cfg_layer), .cfg_en(cfg_en),
      .cfg_x0(cfg_x0), .cfg_x1(cfg_x1), .cfg_y0(cfg_y0), .cfg_y1(cfg_y1),
      .cfg_err(cfg_err), .layer_hit(layer_hit), .layer_rel_h(layer_rel_h),
      .layer_rel_v(layer_rel_v), .layer_rgb(layer_rgb), .rgb_data(rgb_data),
      .frame_commit(frame_commit)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < N; i++) begin
         en_a[i] = 0; x0_a[i] = 0; x1_a[i] = 0; y0_a[i] = 0; y1_a[i] = 0;
         en_s[i] = 0; x0_s[i] = 0; x1_s[i] = 0; y0_s[i] = 0; y1_s[i] = 0;
      end
      pend_m = 0;
      err_m  = 0;
   endtask

   function automatic bit m_hit(int i, int h, int v);
      return (en_a[i] != 0) && (h != 0) && (v != 0) &&
             (h >= x0_a[i]) && (h <= x1_a[i]) && (v >= y0_a[i]) && (v <= y1_a[i]);
   endfunction

   function automatic logic [RW-1:0] m_pick(logic [N-1:0] hits, logic [N*RW-1:0] rg);
      for (int i = N - 1; i >= 0; i--) begin
         if (hits[i] && !(KEYEN && rg[i*RW +: RW] == KEY)) return rg[i*RW +: RW];
      end
      return BG;
   endfunction

   // Streams n addresses from a box, one per cycle, then one blanking cycle.
   task automatic run_stream(input int n, input int hlo, input int hhi,
                             input int vlo, input int vhi, input bit key3);
      logic [N-1:0]    hv, prev_hv;
      logic [N*RW-1:0] rg;
      logic [N*AW-1:0] eh, ev;
      logic [RW-1:0]   exp_rgb;
      int h, v;
      prev_hv = '0;
      for (int c = 0; c <= n; c++) begin
         if (c < n) begin
            h = $urandom_range(hhi, hlo);
            v = $urandom_range(vhi, vlo);
         end else begin
            h = 0;
            v = 0;
         end
         for (int i = 0; i < N; i++)
            rg[i*RW +: RW] = ($urandom_range(7, 0) == 0) ? KEY : RW'($urandom);
         if (key3) rg[3*RW +: RW] = KEY;
         addr_h    = AW'(h);
         addr_v    = AW'(v);
         layer_rgb = rg;
         step();
         hv = '0; eh = '0; ev = '0;
         for (int i = 0; i < N; i++) begin
            if (m_hit(i, h, v)) begin
               hv[i] = 1'b1;
               eh[i*AW +: AW] = AW'(h - x0_a[i]);
               ev[i*AW +: AW] = AW'(v - y0_a[i]);
            end
         end
         checks++;
         if (layer_hit !== hv) begin
            errors++;
            $display("FAIL layer_hit @(%0d,%0d): got %b expected %b", h, v, layer_hit, hv);
         end
         checks++;
         if (layer_rel_h !== eh || layer_rel_v !== ev) begin
            errors++;
            $display("FAIL layer_rel @(%0d,%0d): got h=%h v=%h expected h=%h v=%h",
                     h, v, layer_rel_h, layer_rel_v, eh, ev);
         end
         if (c > 0) begin
            exp_rgb = m_pick(prev_hv, rg);
            checks++;
            if (rgb_data !== exp_rgb) begin
               errors++;
               $display("FAIL rgb_data: got %h expected %h (hits %b)", rgb_data, exp_rgb, prev_hv);
            end
         end
         prev_hv = hv;
      end
   endtask

   task automatic check_commit_cycle(input bit exp_commit);
      checks++;
      if (frame_commit !== exp_commit || cfg_ready !== !exp_commit) begin
         errors++;
         $display("FAIL commit_cycle: got commit=%b ready=%b expected commit=%b ready=%b",
                  frame_commit, cfg_ready, exp_commit, !exp_commit);
      end
      step();
      checks++;
      if (frame_commit !== 1'b0 || cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL after_commit: got commit=%b ready=%b expected commit=0 ready=1",
                  frame_commit, cfg_ready);
      end
      if (exp_commit) begin
         en_a = en_s; x0_a = x0_s; x1_a = x1_s; y0_a = y0_s; y1_a = y1_s;
         pend_m = 0;
      end
      v_sync = 1'b1;
      step();
   endtask

   task automatic cfg_write(input int l, input int en, input int x0, input int x1,
                            input int y0, input int y1, input bit with_edge);
      bit exp_commit;
      cfg_valid = 1'b1;
      cfg_layer = 3'(l);
      cfg_en    = (en != 0);
      cfg_x0 = AW'(x0); cfg_x1 = AW'(x1); cfg_y0 = AW'(y0); cfg_y1 = AW'(y1);
      if (with_edge) v_sync = 1'b0;
      checks++;
      if (cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL cfg_ready_on_write: got %b expected 1", cfg_ready);
      end
      step();
      cfg_valid = 1'b0;
      exp_commit = with_edge && pend_m;
      if (l < N) begin
         en_s[l] = en; x0_s[l] = x0; x1_s[l] = x1; y0_s[l] = y0; y1_s[l] = y1;
         pend_m = 1;
      end else begin
         err_m = 1;
      end
      checks++;
      if (cfg_err !== err_m) begin
         errors++;
         $display("FAIL cfg_err: got %b expected %b", cfg_err, err_m);
      end
      if (with_edge) check_commit_cycle(exp_commit);
   endtask

   task automatic vsync_pulse();
      v_sync = 1'b0;
      step();
      check_commit_cycle(pend_m);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      checks++;
      if (cfg_ready !== 1'b1 || frame_commit !== 1'b0 || cfg_err !== 1'b0 ||
          layer_hit !== '0 || rgb_data !== '0 || layer_rel_h !== '0 || layer_rel_v !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got ready=%b commit=%b err=%b hit=%b rgb=%h expected 1/0/0/0/0",
                  cfg_ready, frame_commit, cfg_err, layer_hit, rgb_data);
      end
      step();
      rst_n = 1'b1;
      step();
      run_stream(200, 0, 640, 0, 480, 1'b0);
      run_stream(4, 1, 1, 1, 1, 1'b0);
      run_stream(4, 640, 640, 480, 480, 1'b0);
   endtask

   task automatic test_single_window();
      cfg_write(0, 1, 10, 19, 20, 29, 1'b0);
      vsync_pulse();
      run_stream(1, 10, 10, 20, 20, 1'b0);
      run_stream(1, 19, 19, 29, 29, 1'b0);
      run_stream(1, 20, 20, 29, 29, 1'b0);
      run_stream(1, 9, 9, 20, 20, 1'b0);
      run_stream(150, 5, 25, 15, 35, 1'b0);
   endtask

   task automatic test_priority();
      cfg_write(1, 1, 90, 110, 90, 110, 1'b0);
      cfg_write(2, 0, 1, 640, 1, 480, 1'b0);
      cfg_write(3, 1, 95, 105, 95, 105, 1'b0);
      vsync_pulse();
      run_stream(2, 100, 100, 100, 100, 1'b0);
      run_stream(100, 85, 115, 85, 115, 1'b0);
      cfg_write(3, 0, 95, 105, 95, 105, 1'b0);
      vsync_pulse();
      run_stream(2, 100, 100, 100, 100, 1'b0);
      run_stream(60, 85, 115, 85, 115, 1'b0);
   endtask

   task automatic test_midframe_and_edge_write();
      cfg_write(1, 1, 300, 310, 300, 310, 1'b0);
      run_stream(2, 100, 100, 100, 100, 1'b0);
      run_stream(2, 305, 305, 305, 305, 1'b0);
      cfg_write(0, 1, 290, 320, 290, 320, 1'b1);
      run_stream(2, 305, 305, 305, 305, 1'b0);
      run_stream(120, 280, 330, 280, 330, 1'b0);
   endtask

   task automatic test_inverted_window();
      cfg_write(2, 1, 50, 40, 1, 480, 1'b0);
      cfg_write(3, 1, 1, 640, 70, 60, 1'b0);
      vsync_pulse();
      run_stream(80, 30, 80, 50, 80, 1'b0);
   endtask

   task automatic test_bad_layer();
      cfg_write(5, 1, 1, 640, 1, 480, 1'b0);
      vsync_pulse();
      run_stream(40, 1, 640, 1, 480, 1'b0);
      cfg_write(7, 1, 1, 640, 1, 480, 1'b1);
      checks++;
      if (cfg_err !== 1'b1) begin
         errors++;
         $display("FAIL cfg_err_sticky: got %b expected 1", cfg_err);
      end
   endtask

   task automatic test_colorkey();
      cfg_write(0, 1, 200, 210, 200, 210, 1'b0);
      cfg_write(3, 1, 200, 210, 200, 210, 1'b0);
      vsync_pulse();
      run_stream(3, 205, 205, 205, 205, 1'b1);
      run_stream(80, 195, 215, 195, 215, 1'b0);
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 3; k++) begin
         cfg_write(int'($urandom_range(3, 0)), 1, int'($urandom_range(100, 1)),
                   int'($urandom_range(200, 50)), int'($urandom_range(100, 1)),
                   int'($urandom_range(200, 50)), 1'b0);
         cfg_write(int'($urandom_range(3, 0)), int'($urandom_range(1, 0)),
                   int'($urandom_range(100, 1)), int'($urandom_range(200, 50)),
                   int'($urandom_range(100, 1)), int'($urandom_range(200, 50)), 1'b1);
         run_stream(150, 0, 220, 0, 220, 1'b0);
      end
   endtask

   task automatic test_reset_mid_commit();
      cfg_write(1, 1, 1, 640, 1, 480, 1'b0);
      v_sync = 1'b0;
      step();
      checks++;
      if (cfg_ready !== 1'b0 || frame_commit !== 1'b1) begin
         errors++;
         $display("FAIL commit_before_reset: got ready=%b commit=%b expected 0/1",
                  cfg_ready, frame_commit);
      end
      rst_n = 1'b0;
      #1;
      model_clear();
      checks++;
      if (cfg_ready !== 1'b1 || frame_commit !== 1'b0 || cfg_err !== 1'b0 ||
          layer_hit !== '0 || rgb_data !== '0) begin
         errors++;
         $display("FAIL reset_mid_commit: got ready=%b commit=%b err=%b hit=%b rgb=%h expected 1/0/0/0/0",
                  cfg_ready, frame_commit, cfg_err, layer_hit, rgb_data);
      end
      v_sync = 1'b1;
      step();
      rst_n = 1'b1;
      step();
      run_stream(60, 1, 640, 1, 480, 1'b0);
      vsync_pulse();
      run_stream(20, 1, 640, 1, 480, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; addr_h = '0; addr_v = '0; v_sync = 1'b1;
      cfg_valid = 1'b0; cfg_layer = '0; cfg_en = 1'b0;
      cfg_x0 = '0; cfg_x1 = '0; cfg_y0 = '0; cfg_y1 = '0; layer_rgb = '0;
      model_clear();
      test_reset();
      test_single_window();
      test_priority();
      test_midframe_and_edge_write();
      test_inverted_window();
      test_bad_layer();
      test_colorkey();
      test_back_to_back();
      test_reset_mid_commit();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
